// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: three-port request sequencer in front of a single-port SDRAM controller.
// Ports: clk/reset (sync, active-high); pN_req/pN_we/pN_addr/pN_din in and pN_ack/pN_dout out
// for N=0 video, 1 CPU, 2 DMA; sd_addr/sd_din/sd_we/sd_ce/sd_refresh out to the controller,
// sd_dout in from it; busy high during init wait or any active slot.
// Each CYCLE_LEN-clock slot carries one ce or refresh strobe, high for its first half.
// Define ROUND_ROBIN_EN to alternate port1/port2 on ties (port0 keeps absolute priority);
// otherwise priority is fixed port0 > port1 > port2.
module sdram_port_arbiter #(
  parameter int CYCLE_LEN = 8,
  parameter int DATA_LAT = 6,
  parameter int REFRESH_INTERVAL = 500,
  parameter int INIT_WAIT = 288
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [24:0] p0_addr,
  input  logic [7:0]  p0_din,
  output logic        p0_ack,
  output logic [7:0]  p0_dout,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [24:0] p1_addr,
  input  logic [7:0]  p1_din,
  output logic        p1_ack,
  output logic [7:0]  p1_dout,
  input  logic        p2_req,
  input  logic        p2_we,
  input  logic [24:0] p2_addr,
  input  logic [7:0]  p2_din,
  output logic        p2_ack,
  output logic [7:0]  p2_dout,
  output logic [24:0] sd_addr,
  output logic [7:0]  sd_din,
  output logic        sd_we,
  output logic        sd_ce,
  output logic        sd_refresh,
  input  logic [7:0]  sd_dout,
  output logic        busy
);
  localparam int SW = $clog2(CYCLE_LEN);
  localparam int RW = $clog2(REFRESH_INTERVAL);
  localparam int IW = $clog2(INIT_WAIT + 1);
  typedef enum logic [1:0] {INIT, IDLE, ACCESS, REFRESH} state_t;
  state_t state, state_n;
  logic [SW-1:0] slot, slot_n;
  logic [RW-1:0] ref_cnt;
  logic [IW-1:0] init_cnt;
  logic pending, wrap, arb, any_req, grant, ref_grant;
  logic [1:0] port, sel_port;
  logic [2:0] ack;
  logic [7:0] dout [3];
`ifdef ROUND_ROBIN_EN
  logic last_p2;
`endif
  // arb is true wherever a new slot may be granted: idle, or the last clock of a slot
  always_comb begin
    any_req = p0_req | p1_req | p2_req;
    arb = state == IDLE || ((state == ACCESS || state == REFRESH) && slot == SW'(CYCLE_LEN - 1));
`ifdef ROUND_ROBIN_EN
    sel_port = p0_req ? 2'd0 : (p1_req && (!p2_req || last_p2)) ? 2'd1 : 2'd2;
`else
    sel_port = p0_req ? 2'd0 : p1_req ? 2'd1 : 2'd2;
`endif
    wrap = ref_cnt == RW'(REFRESH_INTERVAL - 1);
    ref_grant = arb && pending;
    grant = arb && !pending && any_req;
    state_n = state == INIT ? (init_cnt == '0 ? IDLE : INIT) :
              !arb ? state : pending ? REFRESH : any_req ? ACCESS : IDLE;
    slot_n = arb ? '0 : slot + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= INIT;
      init_cnt <= IW'(INIT_WAIT);
      slot <= '0;
      ref_cnt <= '0;
      pending <= 1'b0;
      port <= '0;
      ack <= '0;
      dout <= '{default: '0};
      sd_addr <= '0;
      sd_din <= '0;
      sd_we <= 1'b0;
      sd_ce <= 1'b0;
      sd_refresh <= 1'b0;
      busy <= 1'b0;
`ifdef ROUND_ROBIN_EN
      last_p2 <= 1'b1;
`endif
    end else begin
      state <= state_n;
      slot <= slot_n;
      if (state == INIT && init_cnt != '0) init_cnt <= init_cnt - 1'b1;
      ref_cnt <= wrap ? '0 : ref_cnt + 1'b1;
      // a new wrap beats the clear so a refresh due on the grant clock is not lost
      pending <= wrap || (pending && !ref_grant);
      // strobes are registered from next state so each slot yields one clean edge
      sd_ce <= state_n == ACCESS && slot_n < SW'(CYCLE_LEN / 2);
      sd_refresh <= state_n == REFRESH && slot_n < SW'(CYCLE_LEN / 2);
      busy <= state_n != IDLE;
      ack <= '0;
      if (state == ACCESS && slot == SW'(DATA_LAT)) begin
        ack[port] <= 1'b1;
        if (!sd_we) dout[port] <= sd_dout;
      end
      if (ref_grant) sd_we <= 1'b0;
      if (grant) begin
        port <= sel_port;
        sd_addr <= sel_port == 2'd0 ? p0_addr : sel_port == 2'd1 ? p1_addr : p2_addr;
        sd_din <= sel_port == 2'd0 ? p0_din : sel_port == 2'd1 ? p1_din : p2_din;
        sd_we <= sel_port == 2'd0 ? p0_we : sel_port == 2'd1 ? p1_we : p2_we;
`ifdef ROUND_ROBIN_EN
        if (sel_port != 2'd0) last_p2 <= sel_port[1];
`endif
      end
    end
  end
  assign p0_ack = ack[0];
  assign p1_ack = ack[1];
  assign p2_ack = ack[2];
  assign p0_dout = dout[0];
  assign p1_dout = dout[1];
  assign p2_dout = dout[2];
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb_sdram_port_arbiter: randomized and directed checks of sdram_port_arbiter against a slot-level reference model.
module tb_sdram_port_arbiter;
  localparam int CL = 8, DL = 6, RI = 40, IWT = 30;
  logic clk = 1'b0, reset = 1'b1;
  logic [2:0] req = '0, we = '0;
  logic [24:0] addr [3];
  logic [7:0] din [3];
  logic [7:0] sd_dout = '0;
  logic p0_ack, p1_ack, p2_ack, sd_we, sd_ce, sd_refresh, busy;
  logic [7:0] p0_dout, p1_dout, p2_dout, sd_din;
  logic [24:0] sd_addr;
  logic [2:0] acks;
  logic [7:0] douts [3];
  assign acks = {p2_ack, p1_ack, p0_ack};
  assign douts[0] = p0_dout;
  assign douts[1] = p1_dout;
  assign douts[2] = p2_dout;

  sdram_port_arbiter #(.CYCLE_LEN(CL), .DATA_LAT(DL), .REFRESH_INTERVAL(RI), .INIT_WAIT(IWT)) dut (
    .clk(clk), .reset(reset),
    .p0_req(req[0]), .p0_we(we[0]), .p0_addr(addr[0]), .p0_din(din[0]), .p0_ack(p0_ack), .p0_dout(p0_dout),
    .p1_req(req[1]), .p1_we(we[1]), .p1_addr(addr[1]), .p1_din(din[1]), .p1_ack(p1_ack), .p1_dout(p1_dout),
    .p2_req(req[2]), .p2_we(we[2]), .p2_addr(addr[2]), .p2_din(din[2]), .p2_ack(p2_ack), .p2_dout(p2_dout),
    .sd_addr(sd_addr), .sd_din(sd_din), .sd_we(sd_we), .sd_ce(sd_ce), .sd_refresh(sd_refresh),
    .sd_dout(sd_dout), .busy(busy)
  );

  initial forever #5 clk = ~clk;

  // reference model: clock period index, current slot record, expected client-visible state
  int cyc = 0, rel = 0, s_start = 0, s_port = 0, ack_port = -1;
  bit have_rst = 0, just_rst = 0, pending = 0, slot_on = 0, s_ref = 0, last_p2 = 1;
  logic [24:0] e_addr = '0;
  logic [7:0] e_din = '0;
  logic e_we = 1'b0;
  logic [7:0] e_dout [3] = '{default: '0};
  int vectors = 0, fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h (period %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int pick();
    int p = -1;
`ifdef ROUND_ROBIN_EN
    if (req[0]) p = 0;
    else if (req[1] && req[2]) p = last_p2 ? 1 : 2;
    else if (req[1]) p = 1;
    else if (req[2]) p = 2;
`else
    for (int i = 2; i >= 0; i--) if (req[i]) p = i;
`endif
    return p;
  endfunction

  // applies the rules to the period that ends at this edge, using the inputs held during it
  task automatic model_edge();
    int t = cyc, w = -1, p;
    bit free;
    if (reset) begin
      have_rst = 1; just_rst = 1; rel = t + 1; pending = 0; slot_on = 0; ack_port = -1;
      e_addr = '0; e_din = '0; e_we = 1'b0; last_p2 = 1;
      for (int i = 0; i < 3; i++) e_dout[i] = '0;
    end else if (have_rst) begin
      just_rst = 0;
      if (slot_on && !s_ref && t == s_start + DL) begin
        w = s_port;
        if (!e_we) e_dout[s_port] = sd_dout;
      end
      free = (t >= rel + IWT + 1) && (!slot_on || t == s_start + CL - 1);
      if (free) begin
        slot_on = 0;
        if (pending) begin
          slot_on = 1; s_ref = 1; s_start = t + 1; e_we = 1'b0; pending = 0;
        end else begin
          p = pick();
          if (p >= 0) begin
            slot_on = 1; s_ref = 0; s_start = t + 1; s_port = p;
            e_addr = addr[p]; e_din = din[p]; e_we = we[p];
            if (p > 0) last_p2 = (p == 2);
          end
        end
      end
      if ((t - rel) % RI == RI - 1) pending = 1;
      ack_port = w;
    end
    cyc++;
  endtask

  task automatic check_cycle();
    int pos = cyc - s_start;
    bit ce, rf, by;
    if (!have_rst) return;
    ce = slot_on && !s_ref && pos < CL / 2;
    rf = slot_on && s_ref && pos < CL / 2;
    by = !just_rst && (cyc < rel + IWT + 1 || slot_on);
    chk("sd_ce", sd_ce, ce);
    chk("sd_refresh", sd_refresh, rf);
    chk("ce_refresh_excl", sd_ce & sd_refresh, 0);
    chk("busy", busy, by);
    chk("sd_addr", sd_addr, e_addr);
    chk("sd_din", sd_din, e_din);
    chk("sd_we", sd_we, e_we);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("p%0d_ack", i), acks[i], ack_port == i);
      chk($sformatf("p%0d_dout", i), douts[i], e_dout[i]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_cycle();
  endtask

  task automatic wait_ack(input int p, input int bound);
    int n = 0;
    while (acks[p] !== 1'b1 && n < bound) begin step(); n++; end
    chk($sformatf("p%0d_ack_seen", p), acks[p], 1);
  endtask

  task automatic wait_ce(input int bound);
    int n = 0;
    while (sd_ce !== 1'b1 && n < bound) begin step(); n++; end
    chk("ce_seen", sd_ce, 1);
  endtask

  initial begin
    int c0, seen;
    for (int i = 0; i < 3; i++) begin addr[i] = '0; din[i] = '0; end
    repeat (3) step();
    // init hold-off then a port1 read
    reset = 1'b0;
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 25'h0012345; din[1] = 8'h77; sd_dout = 8'hA5;
    wait_ce(100);
    chk("init_holdoff", cyc, rel + IWT + 2);
    c0 = cyc;
    wait_ack(1, 20);
    chk("rd_ack_time", cyc - c0, CL - 1);
    chk("rd_data", p1_dout, 8'hA5);
    chk("rd_addr", sd_addr, 25'h0012345);
    req[1] = 1'b0;
    step();
    // port2 write at the top address
    req[2] = 1'b1; we[2] = 1'b1; addr[2] = 25'h1FFFFFF; din[2] = 8'h3C;
    wait_ack(2, 40);
    chk("wr_we", sd_we, 1);
    chk("wr_din", sd_din, 8'h3C);
    chk("wr_dout_kept", p2_dout, 8'h00);
    req[2] = 1'b0;
    step();
    // all three ports contending, each dropping on its ack and re-requesting
    for (int i = 0; i < 3; i++) begin
      req[i] = 1'b1; we[i] = 1'(i == 1); addr[i] = 25'($urandom); din[i] = 8'($urandom);
    end
    repeat (80) begin
      sd_dout = 8'($urandom);
      for (int i = 0; i < 3; i++) req[i] = !(ack_port == i);
      step();
    end
    req = '0;
    repeat (10) step();
    // randomized traffic with occasional withdrawal
    repeat (600) begin
      sd_dout = 8'($urandom);
      for (int i = 0; i < 3; i++) begin
        if (req[i] && (ack_port == i || $urandom_range(39) == 0)) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(3) == 0) begin
          req[i] = 1'b1; we[i] = 1'($urandom); addr[i] = 25'($urandom); din[i] = 8'($urandom);
        end
      end
      step();
    end
    req = '0;
    repeat (12) step();
    // reset in the middle of a port0 read
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 25'h0ABCDEF;
    wait_ce(40);
    repeat (3) step();
    req[0] = 1'b0; reset = 1'b1;
    step();
    chk("rst_ce", sd_ce, 0);
    chk("rst_busy", busy, 0);
    chk("rst_addr", sd_addr, 0);
    reset = 1'b0;
    seen = 0;
    repeat (IWT + 20) begin
      step();
      if (p0_ack === 1'b1) seen++;
    end
    chk("no_ack_after_abort", seen, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
